// File: rtl/swg_burst_ctrl.sv
// Command-queued square-wave burst sequencer: (half-period, pulse count) commands
// are buffered in a small FIFO and played back-to-back on a registered output.
module swg_burst_ctrl #(
  parameter int HALF_W     = 16,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [HALF_W-1:0] cmd_half,
  input  logic [CNT_W-1:0]  cmd_pulses,
  input  logic              abort,
  output logic              sq_wave,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulse_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]     PTR_ONE   = 1;
  localparam logic [AW:0]       OCC_ONE   = 1;
  localparam logic [AW:0]       OCC_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [HALF_W-1:0] HALF_ONE  = 1;
  localparam logic [CNT_W-1:0]  PULSE_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW} state_t;

  // FIFO storage and bookkeeping
  logic [HALF_W-1:0] mem_half_q   [FIFO_DEPTH];
  logic [HALF_W-1:0] mem_half_d   [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_pulses_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_pulses_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;

  // Burst engine
  state_t            state_q, state_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [HALF_W-1:0] timer_q, timer_d;
  logic              sq_wave_q, sq_wave_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;

  logic              fifo_empty, fifo_full, push, pop;
  logic [HALF_W-1:0] head_half;
  logic [CNT_W-1:0]  head_pulses;

  assign fifo_empty  = (occ_q == '0);
  assign fifo_full   = (occ_q == OCC_FULL);
  assign cmd_ready   = !rst && !abort && !fifo_full;
  assign push        = cmd_valid && cmd_ready;
  assign head_half   = mem_half_q[rd_ptr_q];
  assign head_pulses = mem_pulses_q[rd_ptr_q];

  assign sq_wave   = sq_wave_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    mem_half_d   = mem_half_q;
    mem_pulses_d = mem_pulses_q;
    if (push) begin
      mem_half_d[wr_ptr_q]   = cmd_half;
      mem_pulses_d[wr_ptr_q] = cmd_pulses;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_ONE;
    end
    // Abort flushes; push is already blocked by cmd_ready while abort is high.
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    sq_wave_d   = sq_wave_q;
    done_d      = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
    pop         = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      sq_wave_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sq_wave_d = 1'b0;
          if (!fifo_empty) begin
            pop         = 1'b1;
            // A zero half-period would underflow the timer; run it as one cycle.
            half_d      = (head_half == '0) ? HALF_ONE : head_half;
            remaining_d = head_pulses;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: begin
          pulse_cnt_d = '0;
          if (remaining_q == '0) begin
            state_d = S_IDLE;
          end else begin
            sq_wave_d = 1'b1;
            timer_d   = half_q - HALF_ONE;
            state_d   = S_HIGH;
          end
        end
        S_HIGH: begin
          if (timer_q == '0) begin
            sq_wave_d = 1'b0;
            timer_d   = half_q - HALF_ONE;
            state_d   = S_LOW;
          end else begin
            timer_d = timer_q - HALF_ONE;
          end
        end
        S_LOW: begin
          if (timer_q == '0) begin
            pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
            remaining_d = remaining_q - PULSE_ONE;
            if (remaining_q == PULSE_ONE) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              sq_wave_d = 1'b1;
              timer_d   = half_q - HALF_ONE;
              state_d   = S_HIGH;
            end
          end else begin
            timer_d = timer_q - HALF_ONE;
          end
        end
        default: begin
          state_d   = S_IDLE;
          sq_wave_d = 1'b0;
        end
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    mem_half_q   <= mem_half_d;
    mem_pulses_q <= mem_pulses_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      state_q     <= S_IDLE;
      half_q      <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      sq_wave_q   <= 1'b0;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      state_q     <= state_d;
      half_q      <= half_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      sq_wave_q   <= sq_wave_d;
      done_q      <= done_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule
